// File: rtl/bp_be_issue_queue_nwide.sv
// N-wide BE issue queue with speculative read pointer and commit checkpoint.
// Optional same-cycle enqueue-to-dequeue forwarding: BP_BE_ISSUE_QUEUE_BYPASS_EN.
module bp_be_issue_queue_nwide #(
  parameter int width_p     = 128,
  parameter int els_p       = 16,
  parameter int enq_width_p = 2,
  parameter int deq_width_p = 2
) (
  input  logic                                 clk_i,
  input  logic                                 reset_i,
  input  logic                                 clr_i,
  input  logic                                 roll_i,
  input  logic [enq_width_p-1:0]               enq_v_i,
  input  logic [enq_width_p*width_p-1:0]       enq_data_i,
  output logic                                 enq_ready_o,
  output logic [deq_width_p-1:0]               deq_v_o,
  output logic [deq_width_p*width_p-1:0]       deq_data_o,
  input  logic [deq_width_p-1:0]               deq_yumi_i,
  input  logic [$clog2(deq_width_p+1)-1:0]     cmt_cnt_i,
  output logic [$clog2(els_p+1)-1:0]           count_o
);

  localparam int idx_w = $clog2(els_p);
  localparam int ptr_w = idx_w + 1;

  typedef logic [ptr_w-1:0] ptr_t;

  ptr_t wptr_r, rptr_r, cptr_r;
  logic [width_p-1:0] mem_r [els_p];

  ptr_t count, avail;
  ptr_t enq_n, deq_n, cptr_n;
  logic [enq_width_p-1:0] enq_acc;

  function automatic ptr_t pop_enq(input logic [enq_width_p-1:0] v);
    ptr_t n;
    n = '0;
    for (int i = 0; i < enq_width_p; i++) n = n + ptr_t'(v[i]);
    return n;
  endfunction

  function automatic ptr_t pop_deq(input logic [deq_width_p-1:0] v);
    ptr_t n;
    n = '0;
    for (int i = 0; i < deq_width_p; i++) n = n + ptr_t'(v[i]);
    return n;
  endfunction

  // Occupancy is measured from the commit point, so speculative reads
  // never free space for the producer.
  assign count       = wptr_r - cptr_r;
  assign avail       = wptr_r - rptr_r;
  assign count_o     = count;
  assign enq_ready_o = (ptr_t'(els_p) - count) >= ptr_t'(enq_width_p);
  assign enq_acc     = enq_v_i & {enq_width_p{enq_ready_o & ~clr_i}};

  assign enq_n  = pop_enq(enq_acc);
  assign deq_n  = pop_deq(deq_yumi_i);
  assign cptr_n = cptr_r + ptr_t'(cmt_cnt_i);

`ifdef BP_BE_ISSUE_QUEUE_BYPASS_EN
  logic bypass;
  assign bypass = (wptr_r == rptr_r) & ~clr_i;
`endif

  for (genvar g = 0; g < deq_width_p; g++) begin : lane
    logic [idx_w-1:0] ra;
    assign ra = rptr_r[idx_w-1:0] + idx_w'(g);
`ifdef BP_BE_ISSUE_QUEUE_BYPASS_EN
    logic               bv;
    logic [width_p-1:0] bd;
    if (g < enq_width_p) begin : fwd
      assign bv = enq_v_i[g] & enq_ready_o;
      assign bd = enq_data_i[g*width_p +: width_p];
    end else begin : nofwd
      assign bv = 1'b0;
      assign bd = '0;
    end
    assign deq_v_o[g] = bypass ? bv : (avail > ptr_t'(g));
    assign deq_data_o[g*width_p +: width_p] = bypass ? bd : mem_r[ra];
`else
    assign deq_v_o[g] = avail > ptr_t'(g);
    assign deq_data_o[g*width_p +: width_p] = mem_r[ra];
`endif
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_r <= '0;
      rptr_r <= '0;
      cptr_r <= '0;
    end else begin
      cptr_r <= cptr_n;
      priority case (1'b1)
        clr_i: begin
          wptr_r <= cptr_n;
          rptr_r <= cptr_n;
        end
        roll_i: begin
          wptr_r <= wptr_r + enq_n;
          rptr_r <= cptr_n;
        end
        default: begin
          wptr_r <= wptr_r + enq_n;
          rptr_r <= rptr_r + deq_n;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < enq_width_p; i++) begin
      if (enq_acc[i])
        mem_r[wptr_r[idx_w-1:0] + idx_w'(i)] <= enq_data_i[i*width_p +: width_p];
    end
  end

endmodule

// File: tb/tb_bp_be_issue_queue_nwide.sv
// Bench for bp_be_issue_queue_nwide: queue-based reference model plus
// directed vectors with hand-computed expectations.
module tb_bp_be_issue_queue_nwide;

  localparam int W  = 16;
  localparam int N  = 16;
  localparam int EW = 2;

  logic           clk = 1'b0;
  logic           reset_i, clr_i, roll_i;
  logic [1:0]     enq_v_i;
  logic [2*W-1:0] enq_data_i;
  logic           enq_ready_o;
  logic [1:0]     deq_v_o;
  logic [2*W-1:0] deq_data_o;
  logic [1:0]     deq_yumi_i;
  logic [1:0]     cmt_cnt_i;
  logic [4:0]     count_o;

  bp_be_issue_queue_nwide #(
    .width_p(W), .els_p(N), .enq_width_p(EW), .deq_width_p(2)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .clr_i(clr_i), .roll_i(roll_i),
    .enq_v_i(enq_v_i), .enq_data_i(enq_data_i), .enq_ready_o(enq_ready_o),
    .deq_v_o(deq_v_o), .deq_data_o(deq_data_o), .deq_yumi_i(deq_yumi_i),
    .cmt_cnt_i(cmt_cnt_i), .count_o(count_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  // Model: q holds every uncommitted entry, oldest first; spec counts
  // how many of them have been handed out speculatively.
  logic [W-1:0] q[$];
  int spec = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  always @(posedge clk) begin
    bit rdy;
    int yc;
    rdy = (N - q.size()) >= EW;
    yc = int'(deq_yumi_i[0]) + int'(deq_yumi_i[1]);
    if (reset_i) begin
      q.delete();
      spec = 0;
    end else begin
      for (int k = 0; k < int'(cmt_cnt_i); k++) void'(q.pop_front());
      spec = spec - int'(cmt_cnt_i);
      if (clr_i) begin
        q.delete();
        spec = 0;
      end else begin
        spec = roll_i ? 0 : spec + yc;
        if (rdy) begin
          if (enq_v_i[0]) q.push_back(enq_data_i[W-1:0]);
          if (enq_v_i[1]) q.push_back(enq_data_i[2*W-1:W]);
        end
      end
    end
  end

  always @(negedge clk) begin
    int av;
    bit rdy;
    logic [1:0] ev;
    logic [W-1:0] ed [2];
    if (started) begin
      av = q.size() - spec;
      rdy = (N - q.size()) >= EW;
      for (int i = 0; i < 2; i++) begin
        ev[i] = av > i;
        ed[i] = ev[i] ? q[spec+i] : '0;
`ifdef BP_BE_ISSUE_QUEUE_BYPASS_EN
        if (av == 0 && !clr_i) begin
          ev[i] = enq_v_i[i] & rdy;
          ed[i] = enq_data_i[i*W +: W];
        end
`endif
      end
      chk("ready", 32'(enq_ready_o), 32'(rdy));
      chk("count", 32'(count_o), 32'(q.size()));
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("deq_v%0d", i), 32'(deq_v_o[i]), 32'(ev[i]));
        if (ev[i])
          chk($sformatf("deq_data%0d", i), 32'(deq_data_o[i*W +: W]), 32'(ed[i]));
      end
    end
  end

  task automatic drive(input logic [1:0] ev, input logic [W-1:0] d0, input logic [W-1:0] d1,
                       input logic [1:0] y, input logic [1:0] c, input logic rl, input logic cl);
    @(posedge clk);
    #1;
    enq_v_i    = ev;
    enq_data_i = {d1, d0};
    deq_yumi_i = y;
    cmt_cnt_i  = c;
    roll_i     = rl;
    clr_i      = cl;
  endtask

  task automatic idle();
    drive(2'b00, '0, '0, 2'b00, 2'd0, 1'b0, 1'b0);
  endtask

  // Legal yumi/commit derived from the model's current state.
  task automatic drive_auto(input logic [1:0] ev, input logic [W-1:0] d0, input logic [W-1:0] d1);
    int av;
    logic [1:0] y;
    logic [1:0] c;
    @(posedge clk);
    #1;
    av = q.size() - spec;
    y = (av >= 2) ? 2'b11 : (av == 1) ? 2'b01 : 2'b00;
    c = (spec >= 2) ? 2'd2 : 2'(spec);
    enq_v_i    = ev;
    enq_data_i = {d1, d0};
    deq_yumi_i = y;
    cmt_cnt_i  = c;
    roll_i     = 1'b0;
    clr_i      = 1'b0;
  endtask

  initial begin
    reset_i = 1'b1; clr_i = 1'b0; roll_i = 1'b0;
    enq_v_i = '0; enq_data_i = '0; deq_yumi_i = '0; cmt_cnt_i = '0;
    repeat (2) @(posedge clk);
    #1 reset_i = 1'b0;
    started = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(enq_ready_o), 32'd1);
    chk("rst_deq_v", 32'(deq_v_o), 32'd0);
    chk("rst_count", 32'(count_o), 32'd0);

    drive(2'b11, 16'hA0A0, 16'hB0B0, 2'b00, 2'd0, 1'b0, 1'b0);
    idle();
    @(negedge clk);
    chk("ab_deq_v", 32'(deq_v_o), 32'd3);
    chk("ab_lane0", 32'(deq_data_o[W-1:0]), 32'hA0A0);
    chk("ab_lane1", 32'(deq_data_o[2*W-1:W]), 32'hB0B0);
    chk("ab_count", 32'(count_o), 32'd2);

    drive(2'b00, '0, '0, 2'b11, 2'd0, 1'b0, 1'b0);
    drive(2'b00, '0, '0, 2'b00, 2'd1, 1'b0, 1'b0);
    drive(2'b00, '0, '0, 2'b00, 2'd0, 1'b1, 1'b0);
    idle();
    @(negedge clk);
    chk("roll_deq_v", 32'(deq_v_o), 32'd1);
    chk("roll_lane0", 32'(deq_data_o[W-1:0]), 32'hB0B0);
    chk("roll_count", 32'(count_o), 32'd1);

    drive(2'b00, '0, '0, 2'b01, 2'd0, 1'b0, 1'b0);
    drive(2'b11, 16'hC0C0, 16'hD0D0, 2'b00, 2'd1, 1'b0, 1'b1);
    idle();
    @(negedge clk);
    chk("clr_deq_v", 32'(deq_v_o), 32'd0);
    chk("clr_count", 32'(count_o), 32'd0);

    drive(2'b01, 16'h1000, '0, 2'b00, 2'd0, 1'b0, 1'b0);
    for (int k = 0; k < 7; k++)
      drive(2'b11, 16'(16'h1001 + 2*k), 16'(16'h1002 + 2*k), 2'b00, 2'd0, 1'b0, 1'b0);
    idle();
    @(negedge clk);
    chk("full_count", 32'(count_o), 32'd15);
    chk("full_ready", 32'(enq_ready_o), 32'd0);
    drive(2'b11, 16'hDEAD, 16'hBEEF, 2'b00, 2'd0, 1'b0, 1'b0);
    idle();
    @(negedge clk);
    chk("drop_count", 32'(count_o), 32'd15);
    drive(2'b00, '0, '0, 2'b11, 2'd0, 1'b0, 1'b0);
    idle();
    @(negedge clk);
    chk("spec_ready", 32'(enq_ready_o), 32'd0);
    chk("spec_count", 32'(count_o), 32'd15);
    drive(2'b00, '0, '0, 2'b00, 2'd2, 1'b0, 1'b0);
    idle();
    @(negedge clk);
    chk("cmt_ready", 32'(enq_ready_o), 32'd1);
    chk("cmt_count", 32'(count_o), 32'd13);
    chk("cmt_lane0", 32'(deq_data_o[W-1:0]), 32'h1002);

    for (int k = 0; k < 40; k++)
      drive_auto(2'b11, 16'(16'h2000 + 2*k), 16'(16'h2001 + 2*k));
    for (int k = 0; k < 14; k++)
      drive_auto(2'b00, '0, '0);
    idle();
    @(negedge clk);
    chk("drain_count", 32'(count_o), 32'd0);
    chk("drain_deq_v", 32'(deq_v_o), 32'd0);

    drive(2'b11, 16'h7777, 16'h8888, 2'b00, 2'd0, 1'b0, 1'b0);
    idle();
    @(posedge clk);
    #1 reset_i = 1'b1;
    @(posedge clk);
    #1 reset_i = 1'b0;
    @(negedge clk);
    chk("mid_rst_count", 32'(count_o), 32'd0);
    chk("mid_rst_deq_v", 32'(deq_v_o), 32'd0);
    chk("mid_rst_ready", 32'(enq_ready_o), 32'd1);

`ifdef BP_BE_ISSUE_QUEUE_BYPASS_EN
    drive(2'b01, 16'hE0E0, '0, 2'b01, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("byp_deq_v", 32'(deq_v_o), 32'd1);
    chk("byp_lane0", 32'(deq_data_o[W-1:0]), 32'hE0E0);
    idle();
    drive(2'b00, '0, '0, 2'b00, 2'd0, 1'b1, 1'b0);
    idle();
    @(negedge clk);
    chk("byp_roll_deq_v", 32'(deq_v_o), 32'd1);
    chk("byp_roll_lane0", 32'(deq_data_o[W-1:0]), 32'hE0E0);
`else
    drive(2'b01, 16'hE0E0, '0, 2'b00, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("lat_same_deq_v", 32'(deq_v_o), 32'd0);
    idle();
    @(negedge clk);
    chk("lat_next_deq_v", 32'(deq_v_o), 32'd1);
    chk("lat_next_lane0", 32'(deq_data_o[W-1:0]), 32'hE0E0);
`endif

    idle();
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bp_be_issue_queue_nwide.md
Name: bp_be_issue_queue_nwide

Overview:
- Parametrised N-wide successor to the single-issue FE-queue buffer in the BE scheduler.
- Buffers fetch packets with up to enq_width_p enqueues and up to deq_width_p speculative dequeues per cycle.
- Keeps a commit checkpoint, so rolled-back (replayed) packets are re-issued without FE refetch.
- Sits between the FE queue interface and dual/multi-issue decode in the scheduler.

Parameters:
width_p, 128, packet width in bits
els_p, 16, entry count; power of 2, at least 2*max(enq_width_p, deq_width_p)
enq_width_p, 2, max enqueues per cycle
deq_width_p, 2, max dequeues/commits per cycle

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous active-high reset
clr_i  in  1  flush all uncommitted entries
roll_i  in  1  rewind speculative read pointer to commit pointer
enq_v_i  in  enq_width_p  per-lane enqueue valid; thermometer from lane 0
enq_data_i  in  enq_width_p*width_p  lane-packed packets; lane 0 oldest
enq_ready_o  out  1  room for enq_width_p entries
deq_v_o  out  deq_width_p  per-lane packet available; thermometer
deq_data_o  out  deq_width_p*width_p  next packets starting at read pointer
deq_yumi_i  in  deq_width_p  per-lane consume; thermometer prefix of deq_v_o
cmt_cnt_i  in  $clog2(deq_width_p+1)  entries committed this cycle
count_o  out  $clog2(els_p+1)  occupancy, wptr minus cptr

Behaviour:
- One clock. Reset is synchronous and active-high.
- Pointers wptr, rptr, cptr are each $clog2(els_p)+1 bits; the MSB is the wrap bit. All arithmetic is mod 2*els_p.
- Invariant: cptr <= rptr <= wptr, in circular order.
- Reset: all pointers 0.
  - Outputs after reset: enq_ready_o=1, deq_v_o=0, count_o=0.
  - deq_data_o is don't-care while its lane is invalid.
- Storage: els_p x width_p register file.
  - Written on enqueue; read combinationally at rptr+i for lane i.
- Enqueue:
  - enq_ready_o = (els_p - count) >= enq_width_p. Conservative; uses cptr, not rptr.
  - A lane accepts only when enq_v_i[i] & enq_ready_o & ~clr_i.
  - wptr += popcount(accepted lanes).
  - A non-thermometer enq_v_i is illegal.
- Dequeue:
  - deq_v_o[i] = (wptr - rptr) > i.
  - rptr += popcount(deq_yumi_i).
  - yumi on an invalid lane is illegal.
- Commit:
  - cptr += cmt_cnt_i every cycle, including clr/roll cycles.
  - cmt_cnt_i exceeding (rptr - cptr) is illegal.
- Roll: rptr_next = cptr_next.
  - Any same-cycle yumi is ignored.
  - Enqueue still proceeds.
- Clear: wptr_next = rptr_next = cptr_next.
  - Enqueue and yumi are discarded.
  - Clear has priority over roll.
- Latency: an entry enqueued in cycle t is visible on deq_v_o in cycle t+1 (without the optional feature).
- Full: enq_ready_o falls when free space < enq_width_p. Speculatively dequeued but uncommitted entries still count as occupied.
- Empty: deq_v_o = 0. Simultaneous enqueue does not set deq_v_o until the next cycle.
- Wrap-around: lane indexing and write addresses use the low $clog2(els_p) bits and wrap naturally. A burst straddling index els_p-1 to 0 is legal.
- Simultaneous enqueue + dequeue + commit in one cycle: all three pointer updates apply independently. count_o reflects the registered pointers only.
- Reset mid-operation: the pointer reset discards all content; the next cycle is identical to post-reset.

Optional Feature:
- Macro: BP_BE_ISSUE_QUEUE_BYPASS_EN.
- Defined:
  - When wptr == rptr and ~clr_i, enqueue lanes are forwarded combinationally to deq lanes in the same cycle: deq_v_o[i] = enq_v_i[i] & enq_ready_o, deq_data_o lane i = enq_data_i lane i.
  - Entries are still written, so roll can replay them; yumi advances rptr normally.
  - Lanes beyond the enqueued count remain invalid.
- Undefined: no bypass; minimum enqueue-to-dequeue latency is 1 cycle.

Test Plan:
- Reset, then 2-lane enqueue of A,B → next cycle deq_v_o=2'b11, data A,B, count_o=2.
- Fill with els_p=16, enq_width_p=2 → enq_ready_o falls when count_o=15. Commit 2 → ready returns the next cycle.
- Dequeue A,B, commit 1, roll → deq lane 0 shows B again; count_o unchanged.
- Enqueue C,D while asserting clr_i with cmt_cnt_i=1 → C,D dropped; deq_v_o=0; count_o = previously committed-pending minus 0, i.e. 0 after that commit.
- Pointer wrap: 40 cycles of 2-in/2-out/2-commit → data order preserved across index 15→0; wrap bit toggles.
- With BP_BE_ISSUE_QUEUE_BYPASS_EN on an empty queue, enqueue E with yumi → E on lane 0 in the same cycle. A later roll (no commit) re-presents E.
